// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS simple core
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {ISSUE, WAIT, DROP} fetch_state_t;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_skid.sv
// ifetch_skid: output register plus one-entry skid buffer for fetched instructions
module ifetch_skid
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t skid;
  logic out_v, skid_v;
  // a push never meets a full skid: the fetch side only issues while the skid is empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dout   <= '0;
      skid   <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop && skid_v) begin
      dout   <= skid;
      skid_v <= 1'b0;
    end else if (push && (!out_v || pop)) begin
      dout  <= din;
      out_v <= 1'b1;
    end else if (push) begin
      skid   <= din;
      skid_v <= 1'b1;
    end else if (pop)
      out_v <= 1'b0;
  assign count = {1'b0, out_v} + {1'b0, skid_v};
  assign full  = skid_v;
  assign empty = !out_v;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC, single-outstanding imem req/ack fetch FSM and redirect handling
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc4,
  input  logic               id_ready,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc
);
  fetch_state_t state, state_d;
  logic [31:0] pc, pc_d, pc_inc, addr_d;
  logic req_d, ack, push, pop, full, empty;
  logic [1:0] count_unused;
  fetch_entry_t din, dout;
  assign ack    = imem_req && imem_ack;
  assign pop    = if_valid && id_ready && !redirect;
  assign pc_inc = pc + 32'd4;
  assign din    = '{instr: imem_rdata, pc4: pc_inc};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= ISSUE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
    end
  always_comb begin
    state_d = state;
    pc_d    = pc;
    req_d   = imem_req;
    addr_d  = imem_addr;
    push    = 1'b0;
    case (state)
      ISSUE: if (!full) begin
        req_d   = 1'b1;
        addr_d  = pc;
        state_d = WAIT;
      end
      WAIT: if (ack) begin
        req_d   = 1'b0;
        push    = 1'b1;
        pc_d    = pc_inc;
        state_d = ISSUE;
      end
      DROP: if (ack) begin
        req_d   = 1'b0;
        state_d = ISSUE;
      end
    endcase
    // redirect wins; any request still open after this edge belongs to the old path
    if (redirect) begin
      push    = 1'b0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      req_d   = ack ? 1'b0 : req_d;
      state_d = ack ? ISSUE : (state_d == ISSUE ? ISSUE : DROP);
    end
  end
  ifetch_skid u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .dout  (dout),
    .count (count_unused),
    .full  (full),
    .empty (empty)
  );
  assign if_valid = !empty;
  assign if_instr = dout.instr;
  assign if_pc4   = dout.pc4;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench with a latency-configurable instruction memory model
module tb_ifetch_unit;
  logic clk = 1'b0, rst_n = 1'b1;
  logic imem_req, imem_ack = 1'b0, if_valid, id_ready = 1'b0, redirect = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0, if_instr, if_pc4, redirect_pc = 32'h0;
  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc4      (if_pc4),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  int vectors = 0, miscompares = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_pc = 32'h0, last_addr = 32'h0, arm_pc = 32'h0;
  bit drop = 1'b0, last_rd = 1'b0, last_req = 1'b0;
  int lat = 0, rc = 0, arm = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h2008_0005 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // one clock: check outputs at negedge, then drive memory/decode/redirect for the next edge
  task automatic cycle(input bit rdy);
    bit ack, rd;
    @(negedge clk);
    if (last_rd) drop = imem_req;
    if (imem_req && !last_req && !drop) chk("addr", imem_addr, exp_pc);
    if (imem_req && last_req) chk("addr_hold", imem_addr, last_addr);
    chk("valid", if_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("instr", if_instr, sb[0][63:32]);
      chk("pc4", if_pc4, sb[0][31:0]);
    end
    if (sb.size() >= 2) chk("req_full", imem_req, 0);
    rc  = (imem_req && !last_req) ? 0 : rc + 1;
    ack = imem_req && rc >= lat;
    rd  = arm == 3 || (arm == 1 && imem_req && !ack) || (arm == 2 && ack && if_valid && rdy);
    if (rd) arm = 0;
    id_ready    = rdy;
    redirect    = rd;
    redirect_pc = arm_pc;
    imem_ack    = ack;
    imem_rdata  = ack ? word(imem_addr) : 32'hDEAD_BEEF;
    if (rd) begin
      sb.delete();
      exp_pc = {arm_pc[31:2], 2'b00};
    end else begin
      if (if_valid && rdy && sb.size() != 0) void'(sb.pop_front());
      if (ack && drop) drop = 1'b0;
      else if (ack) begin
        sb.push_back({word(imem_addr), imem_addr + 32'd4});
        exp_pc = exp_pc + 32'd4;
      end
    end
    last_rd   = rd;
    last_req  = imem_req;
    last_addr = imem_addr;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(rdy);
  endtask

  task automatic fire(input int mode, input logic [31:0] pc, input bit rnd);
    arm    = mode;
    arm_pc = pc;
    for (int i = 0; i < 60 && arm != 0; i++) cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    chk("redirect_fired", arm, 0);
  endtask

  task automatic reset_checks();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n    = 1'b1;
    sb.delete();
    exp_pc   = 32'h0;
    drop     = 1'b0;
    last_rd  = 1'b0;
    last_req = 1'b0;
    arm      = 0;
    rc       = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    release_reset();
    lat = 0;
    run(8, 1'b1);
    run(5, 1'b0);
    run(10, 1'b1);
    lat = 3;
    run(14, 1'b1);
    fire(1, 32'h0040_0103, 1'b0);
    run(14, 1'b1);
    lat = 0;
    fire(2, 32'h0000_1000, 1'b1);
    run(10, 1'b1);
    lat = 1;
    fire(3, 32'hFFFF_FFFC, 1'b0);
    run(10, 1'b1);
    lat = 3;
    for (int i = 0; i < 20 && !(imem_req && !imem_ack); i++) cycle(1'b1);
    chk("wait_reached", imem_req && !imem_ack, 1);
    #2 rst_n = 1'b0;
    imem_ack = 1'b0;
    #1 reset_checks();
    release_reset();
    lat = 0;
    run(8, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the MIPS simple core. Holds the PC, issues one-outstanding-request reads to instruction memory with a req/ack handshake, buffers returned words, and presents them with PC+4 to decode. Decode splits the instruction and feeds `instruction[15:0]` to the sign extender. Decode applies backpressure via `id_ready`. Branch/jump redirects flush the fetch path.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  reset. Asynchronous assertion, active-low.
- `imem_req`  out  1  read request; held high until `imem_ack`.
- `imem_addr`  out  32  word address of the request; stable while `imem_req` is high.
- `imem_ack`  in  1  response valid; sampled only while `imem_req` is high.
- `imem_rdata`  in  32  instruction word; valid with `imem_ack`.
- `if_valid`  out  1  `if_instr` and `if_pc4` hold a valid instruction.
- `if_instr`  out  32  fetched instruction.
- `if_pc4`  out  32  address of `if_instr` + 4.
- `id_ready`  in  1  decode consumes the output this cycle when `if_valid && id_ready`.
- `redirect`  in  1  one-cycle pulse: flush and refetch from `redirect_pc`.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (forced 0).

## Operation
- State machine `ISSUE`, `WAIT`, `DROP`.
  - `ISSUE`: drive `imem_req=1` when the skid is empty; go to `WAIT`.
  - `WAIT`: hold the request. On `imem_ack`, push the word, set `pc <= pc+4`, and return to `ISSUE`.
  - `DROP`: the in-flight response is discarded. On `imem_ack`, go to `ISSUE`.
- Buffer: output register plus one-entry skid (entry = {instr, pc4}).
  - Ack data goes to the output register if it is empty or being consumed this cycle. Otherwise it goes to the skid.
  - On consume, the skid moves to the output.
  - Requests are issued only while the skid is empty, so an acked word always has space.
- Redirect:
  - Clears both buffer entries and sets `pc <= {redirect_pc[31:2],2'b00}`.
  - In `WAIT`, or in `ISSUE` with a request being raised the same cycle, go to `DROP`.
  - Otherwise go to `ISSUE`.
- Redirect has priority over ack and consume in the same cycle. An ack arriving with `redirect` is discarded, the FSM goes to `ISSUE`, and no `DROP` is needed.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- Reset values:
  - `pc=RESET_PC`, state `ISSUE`.
  - `imem_req=0`, `imem_addr=RESET_PC`.
  - `if_valid=0`, `if_instr=0`, `if_pc4=0`, skid empty.
- First `imem_req` goes high in the first cycle after `rst_n` deasserts.
- Request side:
  - `imem_req` and `imem_addr` are registered outputs.
  - Same-cycle ack is legal.
  - Minimum latency is req edge to `if_valid` one cycle after the ack cycle.
- Throughput: with single-cycle ack and `id_ready=1`, there is a gap cycle between requests (ISSUE/WAIT alternate), so the rate is 1 instruction per 2 cycles.
- Backpressure: `if_valid`/`if_instr`/`if_pc4` stay stable while `if_valid && !id_ready`.
- `if_valid` falls the cycle after a redirect. The first post-redirect instruction appears no earlier than 2 cycles after the redirect pulse.
- Reset mid-transaction: all state clears immediately and `imem_req` drops. The memory is required to abandon the transaction.

## Structure
- Shared package `mips_pkg` holds:
  - the fetch state enum (`ISSUE`, `WAIT`, `DROP`);
  - `INSTR_W=32`;
  - the default `RESET_PC` constant.
- Sub-module `ifetch_skid`: two-entry output/skid buffer with push/pop/flush, count, and full/empty flags. The FSM and PC logic stay in `ifetch_unit`.

## Test plan
- Reset release, memory acks in the same cycle with data 32'h2008_0005:
  - `imem_addr` runs 0, 4, 8;
  - `if_instr=32'h2008_0005` with `if_pc4=4`.
- `id_ready=0` for 5 cycles during streaming:
  - at most 2 words are buffered;
  - `imem_req` stays low while the skid is full;
  - outputs stay stable;
  - after release, the words drain in order with no loss or duplication.
- Ack delayed 3 cycles: `imem_addr` is stable throughout `WAIT`, and the word appears one cycle after the ack.
- Redirect to 32'h0040_0103 during `WAIT`:
  - the late ack word is discarded;
  - the next `imem_addr` is 32'h0040_0100;
  - the first `if_pc4` is 32'h0040_0104.
- Redirect in the same cycle as ack and consume: the acked word is never presented, and both buffer entries are cleared.
- PC 32'hFFFF_FFFC fetch: `if_pc4=0` and the next `imem_addr` is 0. Assert `rst_n` low mid-`WAIT`: all outputs take their reset values asynchronously.
